vme_reg_arbiter2: RTL and testbench

// Two-requester round-robin arbiter sharing one VME-style register slave
// (addr, rd/wr strobe, rd/wr done, rd data). Serialises accesses, one outstanding

---
 rtl/vme_reg_arbiter2_if.sv | 57 +++++
 rtl/vme_reg_arbiter2.sv | 135 +++++++++++++
 tb/tb_vme_reg_arbiter2.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vme_reg_arbiter2_if.sv
// Bundles the two requester ports and the shared register-slave port of vme_reg_arbiter2.
// The master modport is the arbiter's view; the slave modport is the surrounding environment.
interface vme_reg_arbiter2_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) ();

  // Requester 0
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_rd;
  logic              m0_wr;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_done;
  logic              m0_err;

  // Requester 1
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_rd;
  logic              m1_wr;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_done;
  logic              m1_err;

  // Shared register slave
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_wdata;
  logic              s_rd_mem;
  logic              s_wr_mem;
  logic [DATA_W-1:0] s_rdata;
  logic              s_rd_done;
  logic              s_wr_done;

  logic [1:0]        grant;

  modport master (
    input  m0_addr, m0_wdata, m0_rd, m0_wr,
    output m0_rdata, m0_done, m0_err,
    input  m1_addr, m1_wdata, m1_rd, m1_wr,
    output m1_rdata, m1_done, m1_err,
    output s_addr, s_wdata, s_rd_mem, s_wr_mem,
    input  s_rdata, s_rd_done, s_wr_done,
    output grant
  );

  modport slave (
    output m0_addr, m0_wdata, m0_rd, m0_wr,
    input  m0_rdata, m0_done, m0_err,
    output m1_addr, m1_wdata, m1_rd, m1_wr,
    input  m1_rdata, m1_done, m1_err,
    input  s_addr, s_wdata, s_rd_mem, s_wr_mem,
    output s_rdata, s_rd_done, s_wr_done,
    input  grant
  );

endinterface

// File: rtl/vme_reg_arbiter2.sv
// Two-requester round-robin arbiter in front of one register slave.
// One transaction in flight; a WAIT-state timer turns a missing ack into an error completion.
module vme_reg_arbiter2 #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 15
) (
  input logic                clk,
  input logic                rst_n,
  vme_reg_arbiter2_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e            state_q;
  logic [1:0]        grant_q;
  logic              sel_q;
  logic              wr_q;
  logic              last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              rd_strb_q;
  logic              wr_strb_q;
  logic [7:0]        timer_q;
  logic [1:0]        done_q;
  logic [1:0]        err_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  logic              req0;
  logic              req1;
  logic              pick1;
  logic              pick_wr;
  logic              ack;
  logic              timeout;
  logic              upd_rdata;
  logic [7:0]        timer_d;
  logic [DATA_W-1:0] rdata_d;

  always_comb begin
    req0      = bus.m0_rd | bus.m0_wr;
    req1      = bus.m1_rd | bus.m1_wr;
    // On a tie the requester that did not finish last wins; last_q=1 favours m0.
    pick1     = req1 & (~req0 | ~last_q);
    pick_wr   = pick1 ? bus.m1_wr : bus.m0_wr;
    ack       = wr_q ? bus.s_wr_done : bus.s_rd_done;
    timer_d   = timer_q + 8'd1;
    timeout   = (timer_d == TIMEOUT_C);
    rdata_d   = ack ? bus.s_rdata : '1;
    // Writes leave the read-data register alone unless they time out.
    upd_rdata = ~ack | ~wr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      sel_q     <= 1'b0;
      wr_q      <= 1'b0;
      last_q    <= 1'b1;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_strb_q <= 1'b0;
      wr_strb_q <= 1'b0;
      timer_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rd_strb_q <= 1'b0;
      wr_strb_q <= 1'b0;
      done_q    <= '0;
      err_q     <= '0;
      unique case (state_q)
        S_IDLE: begin
          if (req0 | req1) begin
            sel_q     <= pick1;
            grant_q   <= pick1 ? 2'b10 : 2'b01;
            addr_q    <= pick1 ? bus.m1_addr : bus.m0_addr;
            wdata_q   <= pick1 ? bus.m1_wdata : bus.m0_wdata;
            wr_q      <= pick_wr;
            // Strobe is registered here so it is high exactly for the ISSUE cycle.
            wr_strb_q <= pick_wr;
            rd_strb_q <= ~pick_wr;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (ack || timeout) begin
            done_q[sel_q] <= 1'b1;
            err_q[sel_q]  <= ~ack;
            if (upd_rdata) begin
              if (sel_q) rdata1_q <= rdata_d;
              else       rdata0_q <= rdata_d;
            end
            state_q <= S_RESP;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_RESP: begin
          last_q  <= sel_q;
          grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.m0_rdata = rdata0_q;
  assign bus.m0_done  = done_q[0];
  assign bus.m0_err   = err_q[0];
  assign bus.m1_rdata = rdata1_q;
  assign bus.m1_done  = done_q[1];
  assign bus.m1_err   = err_q[1];
  assign bus.s_addr   = addr_q;
  assign bus.s_wdata  = wdata_q;
  assign bus.s_rd_mem = rd_strb_q;
  assign bus.s_wr_mem = wr_strb_q;
  assign bus.grant    = grant_q;

endmodule

// File: tb/tb_vme_reg_arbiter2.sv
// Scoreboard bench for vme_reg_arbiter2: tasks push expected completions, a monitor
// records observed done pulses and strobes, and each task pops and compares them.
module tb_vme_reg_arbiter2;

  localparam int AW = 4;
  localparam int DW = 16;
  localparam int TO = 15;

  typedef struct {
    int          id;
    logic        err;
    logic [DW-1:0] rdata;
    int          cyc;
  } ev_t;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            cyc;
  } st_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vme_reg_arbiter2_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  vme_reg_arbiter2 #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: acks k_lat cycles after the strobe cycle, read data = rd_val + address.
  int            k_lat = 1;
  bit            slv_en = 1'b1;
  logic [DW-1:0] rd_val = '0;
  int            cnt = -1;
  bit            pend_wr = 1'b0;
  logic          slv_rd = 1'b0;
  logic          slv_wr = 1'b0;
  logic          inj_rd = 1'b0;

  assign bus.s_rd_done = slv_rd | inj_rd;
  assign bus.s_wr_done = slv_wr;
  assign bus.s_rdata   = rd_val + DW'(bus.s_addr);

  always @(negedge clk) begin
    slv_rd = 1'b0;
    slv_wr = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        if (pend_wr) slv_wr = 1'b1;
        else         slv_rd = 1'b1;
        cnt = -1;
      end
    end
    if (slv_en && (bus.s_rd_mem || bus.s_wr_mem)) begin
      pend_wr = bus.s_wr_mem;
      cnt     = k_lat;
    end
  end

  ev_t        obs_q[$];
  ev_t        exp_q[$];
  st_t        strb_q[$];
  logic [1:0] gnt_q[$];
  logic [1:0] prev_g = 2'b00;
  bit         overlap = 1'b0;
  bit         dual_strb = 1'b0;

  always @(negedge clk) begin
    if (bus.m0_done === 1'b1) obs_q.push_back('{0, bus.m0_err, bus.m0_rdata, cyc});
    if (bus.m1_done === 1'b1) obs_q.push_back('{1, bus.m1_err, bus.m1_rdata, cyc});
    if (bus.m0_done === 1'b1 && bus.m1_done === 1'b1) overlap = 1'b1;
    if (bus.s_rd_mem === 1'b1 || bus.s_wr_mem === 1'b1)
      strb_q.push_back('{bus.s_wr_mem, bus.s_addr, bus.s_wdata, cyc});
    if (bus.s_rd_mem === 1'b1 && bus.s_wr_mem === 1'b1) dual_strb = 1'b1;
    if (bus.grant !== prev_g) begin
      if (bus.grant === 2'b01 || bus.grant === 2'b10) gnt_q.push_back(bus.grant);
      prev_g = bus.grant;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ev(input int budget, output ev_t e, output bit got);
    got = 1'b0;
    e   = '{-1, 1'bx, 'x, -1};
    for (int i = 0; i < budget && !got; i++) begin
      if (obs_q.size() > 0) begin
        e   = obs_q.pop_front();
        got = 1'b1;
      end else begin
        tick();
      end
    end
    if (!got && obs_q.size() > 0) begin
      e   = obs_q.pop_front();
      got = 1'b1;
    end
  endtask

  task automatic clear_logs();
    obs_q.delete();
    strb_q.delete();
    gnt_q.delete();
    overlap   = 1'b0;
    dual_strb = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bus.grant, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err} !== 6'b0) begin
      fails++;
      $display("FAIL reset_ctrl: grant=%b done=%b%b err=%b%b, expected all 0",
               bus.grant, bus.m1_done, bus.m0_done, bus.m1_err, bus.m0_err);
    end
    checks++;
    if ({bus.s_rd_mem, bus.s_wr_mem, bus.s_addr, bus.s_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_slave: rd=%b wr=%b addr=%h wdata=%h, expected all 0",
               bus.s_rd_mem, bus.s_wr_mem, bus.s_addr, bus.s_wdata);
    end
    checks++;
    if (bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      fails++;
      $display("FAIL reset_rdata: m0=%h m1=%h, expected 0000 0000", bus.m0_rdata, bus.m1_rdata);
    end
    rst_n = 1'b1;
    tick();
    clear_logs();
  endtask

  task automatic test_read();
    ev_t e, x;
    bit  got;
    int  t;
    rd_val = 16'h1232;
    k_lat  = 1;
    t = cyc;
    bus.m0_addr = 4'd2;
    bus.m0_rd   = 1'b1;
    exp_q.push_back('{0, 1'b0, 16'h1234, t + 3});
    wait_ev(10, e, got);
    bus.m0_rd = 1'b0;
    x = exp_q.pop_front();
    checks++;
    if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
      fails++;
      $display("FAIL read_done: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
               got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
    end
    checks++;
    if (strb_q.size() != 1 || strb_q[0].wr !== 1'b0 || strb_q[0].addr !== 4'd2 || strb_q[0].cyc != t + 1) begin
      fails++;
      $display("FAIL read_strobe: count=%0d wr=%b addr=%h cyc=%0d, expected 1 read to 2 at cyc %0d",
               strb_q.size(), strb_q.size() > 0 ? strb_q[0].wr : 1'bx,
               strb_q.size() > 0 ? strb_q[0].addr : 4'hx, strb_q.size() > 0 ? strb_q[0].cyc : -1, t + 1);
    end
    repeat (6) tick();
    checks++;
    if (obs_q.size() != 0 || strb_q.size() != 1 || bus.m0_rdata !== 16'h1234) begin
      fails++;
      $display("FAIL read_idle: extra done=%0d strobes=%0d m0_rdata=%h, expected 0 1 1234",
               obs_q.size(), strb_q.size(), bus.m0_rdata);
    end
    clear_logs();
  endtask

  task automatic test_write();
    ev_t e, x;
    bit  got;
    int  t;
    k_lat = 2;
    t = cyc;
    bus.m1_addr  = 4'd0;
    bus.m1_wdata = 16'hBEEF;
    bus.m1_wr    = 1'b1;
    exp_q.push_back('{1, 1'b0, 16'h0000, t + 4});
    wait_ev(12, e, got);
    bus.m1_wr = 1'b0;
    x = exp_q.pop_front();
    checks++;
    if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
      fails++;
      $display("FAIL write_done: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
               got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
    end
    checks++;
    if (strb_q.size() != 1 || strb_q[0].wr !== 1'b1 || strb_q[0].wdata !== 16'hBEEF ||
        strb_q[0].addr !== 4'd0 || strb_q[0].cyc != t + 1) begin
      fails++;
      $display("FAIL write_strobe: count=%0d wdata=%h cyc=%0d, expected one write of BEEF to 0 at cyc %0d",
               strb_q.size(), strb_q.size() > 0 ? strb_q[0].wdata : 16'hxxxx,
               strb_q.size() > 0 ? strb_q[0].cyc : -1, t + 1);
    end
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 0 || bus.m0_rdata !== 16'h1234) begin
      fails++;
      $display("FAIL write_quiet: extra done=%0d m0_rdata=%h, expected 0 1234", obs_q.size(), bus.m0_rdata);
    end
    clear_logs();
  endtask

  task automatic test_back_to_back();
    ev_t        e, x;
    bit         got;
    int         r;
    logic [1:0] gexp[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    k_lat  = 1;
    rd_val = 16'h1000;
    rst_n  = 1'b0;
    bus.m0_addr = 4'd3;
    bus.m1_addr = 4'd5;
    bus.m0_rd   = 1'b1;
    bus.m1_rd   = 1'b1;
    repeat (2) tick();
    clear_logs();
    rst_n = 1'b1;
    r = cyc;
    for (int i = 0; i < 4; i++)
      exp_q.push_back('{i % 2, 1'b0, (i % 2 == 0) ? 16'h1003 : 16'h1005, r + 3 + 4 * i});
    for (int i = 0; i < 4; i++) begin
      wait_ev(12, e, got);
      x = exp_q.pop_front();
      checks++;
      if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
        fails++;
        $display("FAIL b2b_done%0d: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
                 i, got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
      end
    end
    bus.m0_rd = 1'b0;
    bus.m1_rd = 1'b0;
    repeat (6) tick();
    checks++;
    if (gnt_q.size() < 4 || gnt_q[0] !== gexp[0] || gnt_q[1] !== gexp[1] ||
        gnt_q[2] !== gexp[2] || gnt_q[3] !== gexp[3]) begin
      fails++;
      $display("FAIL b2b_grants: count=%0d first=%b, expected 01,10,01,10",
               gnt_q.size(), gnt_q.size() > 0 ? gnt_q[0] : 2'bxx);
    end
    checks++;
    if (overlap || gnt_q.size() != 4 || obs_q.size() != 0) begin
      fails++;
      $display("FAIL b2b_overlap: overlap=%0b grants=%0d extra done=%0d, expected 0 4 0",
               overlap, gnt_q.size(), obs_q.size());
    end
    clear_logs();
  endtask

  task automatic test_timeout();
    ev_t e, x;
    bit  got;
    int  t;
    slv_en = 1'b0;
    t = cyc;
    bus.m0_addr = 4'd1;
    bus.m0_rd   = 1'b1;
    exp_q.push_back('{0, 1'b1, 16'hFFFF, t + 2 + TO});
    wait_ev(40, e, got);
    bus.m0_rd = 1'b0;
    x = exp_q.pop_front();
    checks++;
    if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
      fails++;
      $display("FAIL timeout_done: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
               got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
    end
    tick();
    inj_rd = 1'b1;
    repeat (2) tick();
    inj_rd = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 0 || strb_q.size() != 1 || bus.m0_rdata !== 16'hFFFF) begin
      fails++;
      $display("FAIL timeout_stale: extra done=%0d strobes=%0d m0_rdata=%h, expected 0 1 ffff",
               obs_q.size(), strb_q.size(), bus.m0_rdata);
    end
    slv_en = 1'b1;
    clear_logs();
  endtask

  task automatic test_rd_wr_same();
    ev_t e, x;
    bit  got;
    int  t;
    k_lat  = 1;
    rd_val = 16'h2000;
    t = cyc;
    bus.m0_addr  = 4'd7;
    bus.m0_wdata = 16'h5A5A;
    bus.m0_rd    = 1'b1;
    bus.m0_wr    = 1'b1;
    exp_q.push_back('{0, 1'b0, 16'hFFFF, t + 3});
    exp_q.push_back('{0, 1'b0, 16'h2007, t + 7});
    for (int i = 0; i < 2; i++) begin
      wait_ev(12, e, got);
      if (i == 0) bus.m0_wr = 1'b0;
      else        bus.m0_rd = 1'b0;
      x = exp_q.pop_front();
      checks++;
      if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
        fails++;
        $display("FAIL rdwr_done%0d: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
                 i, got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
      end
    end
    repeat (4) tick();
    checks++;
    if (strb_q.size() != 2 || strb_q[0].wr !== 1'b1 || strb_q[0].wdata !== 16'h5A5A ||
        strb_q[1].wr !== 1'b0 || dual_strb) begin
      fails++;
      $display("FAIL rdwr_order: strobes=%0d first_wr=%b second_wr=%b dual=%0b, expected 2 1 0 0",
               strb_q.size(), strb_q.size() > 0 ? strb_q[0].wr : 1'bx,
               strb_q.size() > 1 ? strb_q[1].wr : 1'bx, dual_strb);
    end
    clear_logs();
  endtask

  task automatic test_reset_in_wait();
    ev_t e, x;
    bit  got;
    int  r;
    slv_en = 1'b0;
    rd_val = 16'h3000;
    bus.m0_addr = 4'd4;
    bus.m1_addr = 4'd9;
    bus.m0_rd   = 1'b1;
    bus.m1_rd   = 1'b1;
    for (int i = 0; i < 10 && strb_q.size() == 0; i++) tick();
    checks++;
    if (strb_q.size() != 1 || bus.grant !== 2'b10) begin
      fails++;
      $display("FAIL rstwait_grant: strobes=%0d grant=%b, expected 1 10", strb_q.size(), bus.grant);
    end
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if ({bus.grant, bus.m0_done, bus.m1_done, bus.m0_err, bus.m1_err, bus.s_rd_mem, bus.s_wr_mem} !== '0 ||
        bus.s_addr !== '0 || bus.s_wdata !== '0 || bus.m0_rdata !== '0 || bus.m1_rdata !== '0) begin
      fails++;
      $display("FAIL rstwait_zero: grant=%b done=%b%b addr=%h m0_rdata=%h m1_rdata=%h, expected all 0",
               bus.grant, bus.m1_done, bus.m0_done, bus.s_addr, bus.m0_rdata, bus.m1_rdata);
    end
    slv_en = 1'b1;
    k_lat  = 1;
    rst_n  = 1'b1;
    r = cyc;
    checks++;
    if (obs_q.size() != 0) begin
      fails++;
      $display("FAIL rstwait_nodone: done pulses=%0d, expected 0", obs_q.size());
    end
    exp_q.push_back('{0, 1'b0, 16'h3004, r + 3});
    exp_q.push_back('{1, 1'b0, 16'h3009, r + 7});
    for (int i = 0; i < 2; i++) begin
      wait_ev(12, e, got);
      if (e.id == 0) bus.m0_rd = 1'b0;
      if (e.id == 1) bus.m1_rd = 1'b0;
      x = exp_q.pop_front();
      checks++;
      if (!got || e.id !== x.id || e.err !== x.err || e.rdata !== x.rdata || e.cyc !== x.cyc) begin
        fails++;
        $display("FAIL rstwait_done%0d: got=%0b id=%0d err=%b rdata=%h cyc=%0d, expected id=%0d err=%b rdata=%h cyc=%0d",
                 i, got, e.id, e.err, e.rdata, e.cyc, x.id, x.err, x.rdata, x.cyc);
      end
    end
    bus.m0_rd = 1'b0;
    bus.m1_rd = 1'b0;
    repeat (4) tick();
    clear_logs();
  endtask

  initial begin
    bus.m0_addr  = '0;
    bus.m0_wdata = '0;
    bus.m0_rd    = 1'b0;
    bus.m0_wr    = 1'b0;
    bus.m1_addr  = '0;
    bus.m1_wdata = '0;
    bus.m1_rd    = 1'b0;
    bus.m1_wr    = 1'b0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_timeout();
    test_rd_wr_same();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
